// File: rtl/adc_lvds_pkg.sv
// Shared encodings and PRBS-7 helpers for the ADC LVDS framing blocks.
package adc_lvds_pkg;

    typedef enum logic [1:0] {
        MODE_DATA  = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_PRBS  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [7:0] TRAIN_WORD = 8'hF0;
    localparam logic [7:0] IDLE_WORD  = 8'h00;

    // x^7 + x^6 + 1: feedback is the XOR of state bits 6 and 5
    localparam int unsigned PRBS_TAP_HI = 6;
    localparam int unsigned PRBS_TAP_LO = 5;
    // All-zero is the LFSR lockup state, so a zero seed is substituted
    localparam logic [6:0] PRBS_ZERO_SEED_SUB = 7'h7F;

    // Advance the LFSR eight steps; returns {next_state, word}.
    // Each step's freshly generated bit is the output bit, first bit at MSB.
    function automatic logic [14:0] prbs7_advance8(input logic [6:0] state);
        logic [6:0] s;
        logic [7:0] w;
        logic       fb;
        s = state;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            fb       = s[PRBS_TAP_HI] ^ s[PRBS_TAP_LO];
            w[7 - k] = fb;
            s        = {s[5:0], fb};
        end
        return {s, w};
    endfunction

endpackage

// File: rtl/prbs7_byte_gen.sv
// PRBS-7 byte generator: holds the LFSR and presents the next 8 output bits.
module prbs7_byte_gen
    import adc_lvds_pkg::*;
#(
    parameter logic [6:0] SEED = 7'h5A
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       advance,
    output logic [7:0] data_byte
);

    localparam logic [6:0] INIT = (SEED == 7'h00) ? PRBS_ZERO_SEED_SUB : SEED;

    logic [6:0] lfsr_q;
    logic [6:0] lfsr_d;

    // Byte for this cycle and the LFSR state eight steps ahead
    always_comb begin
        {lfsr_d, data_byte} = prbs7_advance8(lfsr_q);
    end

    // LFSR only moves when its byte is consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= INIT;
        end else if (advance) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/adc_lvds_tx_framer.sv
// Transmit framer: training, test patterns and user data onto per-lane words.
module adc_lvds_tx_framer
    import adc_lvds_pkg::*;
#(
    parameter int unsigned LANES     = 8,
    parameter int unsigned SYNC_LEN  = 16,
    parameter logic [6:0]  PRBS_SEED = 7'h5A
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [7:0]           fixed_pattern,
    input  logic [LANES*8-1:0]   s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [LANES*8-1:0]   lane_words,
    output logic [7:0]           frame_word,
    output logic                 tx_active,
    output logic                 sync_done,
    output logic [15:0]          underflow_cnt
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);

    state_e             state;
    logic [7:0]         sync_cnt;
    logic [7:0]         ramp_cnt;
    logic [7:0]         prbs_word;
    logic               prbs_advance;
    logic               in_run;
    mode_e              mode_sel;
    logic [LANES*8-1:0] run_words;

    assign mode_sel     = mode_e'(mode);
    assign in_run       = (state == ST_RUN);
    // Handshake is combinational on mode so a mode change acts the same cycle
    assign s_ready      = in_run && (mode_sel == MODE_DATA);
    assign prbs_advance = in_run && (mode_sel == MODE_PRBS);

    prbs7_byte_gen #(
        .SEED (PRBS_SEED)
    ) u_prbs (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (prbs_advance),
        .data_byte (prbs_word)
    );

    // Lane content selected while in RUN
    always_comb begin
        run_words = '0;
        case (mode_sel)
            MODE_DATA: begin
                run_words = s_valid ? s_data : {LANES{IDLE_WORD}};
            end
            MODE_FIXED: begin
                for (int i = 0; i < LANES; i++) run_words[8*i +: 8] = fixed_pattern;
            end
            MODE_RAMP: begin
                for (int i = 0; i < LANES; i++) run_words[8*i +: 8] = ramp_cnt + 8'(i);
            end
            MODE_PRBS: begin
                for (int i = 0; i < LANES; i++) run_words[8*i +: 8] = prbs_word;
            end
            default: run_words = '0;
        endcase
    end

    // Link FSM; status flags are registered with the words they describe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            sync_cnt      <= '0;
            ramp_cnt      <= '0;
            lane_words    <= '0;
            frame_word    <= '0;
            tx_active     <= 1'b0;
            sync_done     <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lane_words <= {LANES{IDLE_WORD}};
                    frame_word <= IDLE_WORD;
                    tx_active  <= 1'b0;
                    sync_done  <= 1'b0;
                    sync_cnt   <= '0;
                    if (enable) state <= ST_SYNC;
                end
                ST_SYNC: begin
                    lane_words <= {LANES{TRAIN_WORD}};
                    frame_word <= TRAIN_WORD;
                    tx_active  <= 1'b1;
                    sync_done  <= 1'b0;
                    sync_cnt   <= sync_cnt + 8'd1;
                    if (!enable) begin
                        state <= ST_IDLE;
                    end else if (sync_cnt == SYNC_LAST) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    lane_words <= run_words;
                    frame_word <= TRAIN_WORD;
                    tx_active  <= 1'b1;
                    sync_done  <= 1'b1;
                    if (mode_sel == MODE_RAMP) ramp_cnt <= ramp_cnt + 8'd1;
                    if ((mode_sel == MODE_DATA) && !s_valid && (underflow_cnt != 16'hFFFF)) begin
                        underflow_cnt <= underflow_cnt + 16'd1;
                    end
                    if (!enable) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
